// File: rtl/rtc_bridge_pkg.sv
// Shared types and constants for the RTC port bridge: FSM states, status bit
// positions and the default base port.
package rtc_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2,
    TMO  = 2'd3
  } state_t;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_ERR  = 2;
  localparam int STAT_OVR  = 3;

  localparam logic [7:0] DEFAULT_BASE_PORT = 8'h21;

  // Index width that stays legal for a single-register map.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rtc_bridge_timeout.sv
// Loadable down-counter for the bridge engine watchdog; expire is high while
// running with the count exhausted.
module rtc_bridge_timeout #(
  parameter int TMO_CYC = 1024,
  localparam int CNT_W = $clog2(TMO_CYC + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic run,
  output logic expire
);

  logic [CNT_W-1:0] cnt_reg;

  // Loaded with TMO_CYC-1 on entry so expiry lands on the TMO_CYC-th busy cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= CNT_W'(TMO_CYC - 1);
    end else if (run && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign expire = run && (cnt_reg == '0);

endmodule

// File: rtl/rtc_port_bridge.sv
// CPU port-mapped bridge to an RTC register engine with sticky status flags.
// Optional engine watchdog enabled by defining RTC_BRIDGE_TIMEOUT_EN.
module rtc_port_bridge
  import rtc_bridge_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int PORT_W    = 8,
  parameter int NREG      = 11,
  parameter int BASE_PORT = int'(DEFAULT_BASE_PORT),
  parameter int TMO_CYC   = 1024,
  localparam int IDX_W    = idx_width(NREG)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PORT_W-1:0] port_id,
  input  logic [DATA_W-1:0] out_port,
  input  logic              write_strobe,
  input  logic              read_strobe,
  output logic [DATA_W-1:0] in_port,
  output logic [IDX_W-1:0]  eng_idx,
  output logic [DATA_W-1:0] eng_wdata,
  output logic              eng_wr_req,
  output logic              eng_rd_req,
  input  logic              eng_done,
  input  logic [DATA_W-1:0] eng_rdata,
  output logic              busy,
  output logic              err
);

  localparam logic [PORT_W-1:0] STATUS_PORT = PORT_W'(BASE_PORT + NREG);
  localparam logic [PORT_W-1:0] RDREQ_PORT  = PORT_W'(BASE_PORT + NREG + 1);
  localparam logic [PORT_W-1:0] DATA_PORT   = PORT_W'(BASE_PORT + NREG + 2);

  state_t            state_reg, state_next;
  logic [IDX_W-1:0]  idx_reg, idx_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic [DATA_W-1:0] rdata_reg, in_port_reg;
  logic              done_reg, err_reg, ovr_reg, clr_pend_reg;
  logic              set_done, set_err, set_ovr, start, expire;
  logic [PORT_W:0]   off;
  logic              reg_hit, rdreq_hit, mapped_wr, rdreq_ok;
  logic [DATA_W-1:0] status, rd_mux;

  // Extra bit catches ports below the base as a negative offset.
  assign off       = {1'b0, port_id} - (PORT_W + 1)'(BASE_PORT);
  assign reg_hit   = !off[PORT_W] && (off < (PORT_W + 1)'(NREG));
  assign rdreq_hit = (port_id == RDREQ_PORT);
  assign mapped_wr = write_strobe && (reg_hit || rdreq_hit);
  assign rdreq_ok  = (out_port < DATA_W'(NREG));

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    wdata_next = wdata_reg;
    set_done   = 1'b0;
    set_err    = 1'b0;
    set_ovr    = 1'b0;
    start      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (write_strobe && reg_hit) begin
          idx_next   = off[IDX_W-1:0];
          wdata_next = out_port;
          state_next = WR;
          start      = 1'b1;
        end else if (write_strobe && rdreq_hit) begin
          if (rdreq_ok) begin
            idx_next   = out_port[IDX_W-1:0];
            state_next = RD;
            start      = 1'b1;
          end else begin
            set_err = 1'b1;
          end
        end
      end
      WR, RD: begin
        set_ovr = mapped_wr;
        if (eng_done) begin
          state_next = IDLE;
          set_done   = 1'b1;
        end else if (expire) begin
          state_next = TMO;
          set_err    = 1'b1;
        end
      end
      TMO: begin
        set_ovr    = mapped_wr;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef RTC_BRIDGE_TIMEOUT_EN
  rtc_bridge_timeout #(
    .TMO_CYC(TMO_CYC)
  ) u_timeout (
    .clk   (clk),
    .reset (reset),
    .load  (start),
    .run   ((state_reg == WR) || (state_reg == RD)),
    .expire(expire)
  );
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = ^TMO_CYC;
  assign expire         = 1'b0;
`endif

  always_comb begin
    status            = '0;
    status[STAT_BUSY] = busy;
    status[STAT_DONE] = done_reg;
    status[STAT_ERR]  = err_reg;
    status[STAT_OVR]  = ovr_reg;
    rd_mux            = '0;
    if (port_id == STATUS_PORT) begin
      rd_mux = status;
    end else if (port_id == DATA_PORT) begin
      rd_mux = rdata_reg;
    end
  end

  // Flags clear one cycle after a status read is captured; new events win.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      idx_reg      <= '0;
      wdata_reg    <= '0;
      rdata_reg    <= '0;
      in_port_reg  <= '0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
      ovr_reg      <= 1'b0;
      clr_pend_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      idx_reg      <= idx_next;
      wdata_reg    <= wdata_next;
      in_port_reg  <= rd_mux;
      clr_pend_reg <= read_strobe && (port_id == STATUS_PORT);
      done_reg     <= set_done || (done_reg && !clr_pend_reg);
      err_reg      <= set_err  || (err_reg  && !clr_pend_reg);
      ovr_reg      <= set_ovr  || (ovr_reg  && !clr_pend_reg);
      if ((state_reg == RD) && eng_done) begin
        rdata_reg <= eng_rdata;
      end
    end
  end

  assign busy       = (state_reg != IDLE);
  assign eng_wr_req = (state_reg == WR);
  assign eng_rd_req = (state_reg == RD);
  assign eng_idx    = idx_reg;
  assign eng_wdata  = wdata_reg;
  assign in_port    = in_port_reg;
  assign err        = err_reg;

endmodule
